// File: rtl/led_frame_buffer_pkg.sv
// led_frame_buffer_pkg: shared LED/colour geometry defaults for the frame store and its neighbours.
package led_frame_buffer_pkg;
   localparam int NUM_LEDS_DEF = 64;
   localparam int ADDR_W_DEF   = 8;
   localparam int COLOR_W_DEF  = 8;
   function automatic int ram_aw(input int num_leds);
      return $clog2(2 * num_leds);
   endfunction
endpackage

// File: rtl/led_frame_buffer_if.sv
// led_frame_buffer_if: pixel write channel from the pattern generator into the back buffer.
interface led_frame_buffer_if
   import led_frame_buffer_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int COLOR_W = COLOR_W_DEF
);
   logic               valid;
   logic               ready;
   logic [ADDR_W-1:0]  addr;
   logic [COLOR_W-1:0] red;
   logic [COLOR_W-1:0] green;
   logic [COLOR_W-1:0] blue;
   logic               commit;
   modport master (output valid, addr, red, green, blue, commit, input ready);
   modport slave  (input valid, addr, red, green, blue, commit, output ready);
endinterface

// File: rtl/led_frame_buffer_dpram.sv
// fb_dpram: simple dual-port RAM, one write port and one registered read port (BRAM-inferable).
module fb_dpram
   import led_frame_buffer_pkg::*;
#(
   parameter int DEPTH = 2 * NUM_LEDS_DEF,
   parameter int AW    = ram_aw(NUM_LEDS_DEF),
   parameter int DW    = 3 * COLOR_W_DEF
)(
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);
   logic [DW-1:0] mem [DEPTH];
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end
endmodule

// File: rtl/led_frame_buffer.sv
// led_frame_buffer: ping-pong RGB frame store; the writer fills the back bank and
// the banks swap only at the driver's frame boundary so a frame never tears.
module led_frame_buffer
   import led_frame_buffer_pkg::*;
#(
   parameter int NUM_LEDS = NUM_LEDS_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int COLOR_W  = COLOR_W_DEF
)(
   input  logic               clk,
   input  logic               reset_n,
   led_frame_buffer_if.slave  wr,
   input  logic [ADDR_W-1:0]  rd_address,
   output logic [COLOR_W-1:0] red_out,
   output logic [COLOR_W-1:0] green_out,
   output logic [COLOR_W-1:0] blue_out,
   output logic               swap_pulse,
   output logic               addr_err
);
   localparam int RAW = ram_aw(NUM_LEDS);
   localparam logic [ADDR_W:0] LIM = (ADDR_W + 1)'(NUM_LEDS);
   localparam logic [RAW-1:0] BANK = RAW'(NUM_LEDS);
   // A single LED never moves rd_address off 0, so no frame boundary could ever occur.
   if (NUM_LEDS < 2 || NUM_LEDS > 256 || NUM_LEDS > (1 << ADDR_W)) begin : g_bad_cfg
      $error("led_frame_buffer: NUM_LEDS must be 2..256 and fit in ADDR_W");
   end
   logic                 front_sel, commit_pend, have_frame, rd_ok;
   logic [ADDR_W-1:0]    rd_prev;
   logic                 fire, wr_in, rd_in, boundary, swap, we;
   logic                 front_nx, commit_nx, have_nx;
   logic [RAW-1:0]       waddr, raddr;
   logic [3*COLOR_W-1:0] rdata;
   assign wr.ready = !commit_pend;
   always_comb begin
      fire      = wr.valid & wr.ready;
      wr_in     = {1'b0, wr.addr} < LIM;
      rd_in     = {1'b0, rd_address} < LIM;
      boundary  = (rd_address == '0) && (rd_prev != '0);
      swap      = boundary & commit_pend;
      we        = fire & wr_in;
      front_nx  = front_sel ^ swap;
      commit_nx = swap ? 1'b0 : commit_pend | (fire & wr.commit);
      have_nx   = have_frame | swap;
      waddr     = (front_sel ? '0 : BANK) + RAW'(wr.addr);
      // Read from the post-swap bank so the swap edge already shows the new frame.
      raddr     = (front_nx ? BANK : '0) + (rd_in ? RAW'(rd_address) : '0);
      {red_out, green_out, blue_out} = rd_ok ? rdata : '0;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         front_sel   <= 1'b0;
         commit_pend <= 1'b0;
         have_frame  <= 1'b0;
         rd_ok       <= 1'b0;
         rd_prev     <= '0;
         swap_pulse  <= 1'b0;
         addr_err    <= 1'b0;
      end else begin
         front_sel   <= front_nx;
         commit_pend <= commit_nx;
         have_frame  <= have_nx;
         rd_ok       <= have_nx & rd_in;
         rd_prev     <= rd_address;
         swap_pulse  <= swap;
         addr_err    <= addr_err | (fire & !wr_in);
      end
   end
   fb_dpram #(.DEPTH(2 * NUM_LEDS), .AW(RAW), .DW(3 * COLOR_W)) u_ram (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wdata ({wr.red, wr.green, wr.blue}),
      .raddr (raddr),
      .rdata (rdata)
   );
endmodule

// File: tb/tb_led_frame_buffer.sv
// tb_led_frame_buffer: directed scenarios for the ping-pong frame store with hand-computed colours.
module tb_led_frame_buffer;
   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] rd_address = 8'd0;
   logic [7:0] red_out, green_out, blue_out;
   logic       swap_pulse, addr_err;
   logic [23:0] rgb;
   int tests = 0;
   int fails = 0;

   led_frame_buffer_if #(.ADDR_W(8), .COLOR_W(8)) wr_bus ();

   led_frame_buffer #(.NUM_LEDS(64), .ADDR_W(8), .COLOR_W(8)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .wr         (wr_bus),
      .rd_address (rd_address),
      .red_out    (red_out),
      .green_out  (green_out),
      .blue_out   (blue_out),
      .swap_pulse (swap_pulse),
      .addr_err   (addr_err)
   );

   always #5 clk = ~clk;
   assign rgb = {red_out, green_out, blue_out};

   task automatic beat(input logic [7:0] a, input logic [7:0] r, input logic [7:0] g,
                       input logic [7:0] b, input logic c);
      wr_bus.valid = 1'b1;
      wr_bus.addr = a;
      wr_bus.red = r;
      wr_bus.green = g;
      wr_bus.blue = b;
      wr_bus.commit = c;
      @(negedge clk);
      wr_bus.valid = 1'b0;
      wr_bus.commit = 1'b0;
   endtask

   task automatic read_at(input logic [7:0] a);
      rd_address = a;
      @(negedge clk);
   endtask

   task automatic wrap();
      read_at(8'd63);
      read_at(8'd0);
   endtask

   task automatic test_reset();
      tests++; if (rgb !== 24'h0) begin fails++; $display("FAIL reset_rgb got=%h exp=%h", rgb, 24'h0); end
      tests++; if (wr_bus.ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", wr_bus.ready); end
      tests++; if (addr_err !== 1'b0) begin fails++; $display("FAIL reset_addr_err got=%b exp=0", addr_err); end
      for (int k = 0; k < 64; k++) begin
         read_at(8'(k));
         tests++;
         if (rgb !== 24'h0 || swap_pulse !== 1'b0 || wr_bus.ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_sweep idx=%0d rgb=%h swap=%b ready=%b exp rgb=0 swap=0 ready=1", k, rgb, swap_pulse, wr_bus.ready);
         end
      end
   endtask

   task automatic test_write_commit();
      for (int k = 0; k < 64; k++) beat(8'(k), 8'(k), ~8'(k), 8'h5A, k == 63);
      tests++; if (wr_bus.ready !== 1'b0) begin fails++; $display("FAIL commit_ready got=%b exp=0", wr_bus.ready); end
      tests++; if (swap_pulse !== 1'b0) begin fails++; $display("FAIL commit_early_swap got=%b exp=0", swap_pulse); end
      tests++; if (rgb !== 24'h0) begin fails++; $display("FAIL commit_pre_swap_rgb got=%h exp=%h", rgb, 24'h0); end
      wrap();
      tests++; if (swap_pulse !== 1'b1) begin fails++; $display("FAIL wrap_swap got=%b exp=1", swap_pulse); end
      tests++; if (rgb !== 24'h00FF5A) begin fails++; $display("FAIL wrap_idx0 got=%h exp=%h", rgb, 24'h00FF5A); end
      read_at(8'd10);
      tests++; if (swap_pulse !== 1'b0) begin fails++; $display("FAIL swap_one_cycle got=%b exp=0", swap_pulse); end
      tests++; if (rgb !== 24'h0AF55A) begin fails++; $display("FAIL read_idx10 got=%h exp=%h", rgb, 24'h0AF55A); end
      tests++; if (wr_bus.ready !== 1'b1) begin fails++; $display("FAIL ready_after_swap got=%b exp=1", wr_bus.ready); end
   endtask

   task automatic test_hold_ready();
      beat(8'd10, 8'h11, 8'h22, 8'h33, 1'b1);
      wr_bus.valid = 1'b1;
      wr_bus.addr = 8'd10;
      wr_bus.red = 8'h99;
      wr_bus.green = 8'h99;
      wr_bus.blue = 8'h99;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         tests++;
         if (wr_bus.ready !== 1'b0 || rgb !== 24'h0AF55A || swap_pulse !== 1'b0) begin
            fails++;
            $display("FAIL hold_blocked cyc=%0d ready=%b rgb=%h swap=%b exp ready=0 rgb=0af55a swap=0", i, wr_bus.ready, rgb, swap_pulse);
         end
      end
      wr_bus.valid = 1'b0;
      wrap();
      tests++; if (swap_pulse !== 1'b1) begin fails++; $display("FAIL hold_swap got=%b exp=1", swap_pulse); end
      read_at(8'd10);
      tests++; if (rgb !== 24'h112233) begin fails++; $display("FAIL hold_new_frame got=%h exp=%h", rgb, 24'h112233); end
   endtask

   task automatic test_commit_on_wrap();
      read_at(8'd63);
      rd_address = 8'd0;
      beat(8'd5, 8'h77, 8'h88, 8'h99, 1'b1);
      tests++; if (swap_pulse !== 1'b0) begin fails++; $display("FAIL same_cycle_swap got=%b exp=0", swap_pulse); end
      tests++; if (wr_bus.ready !== 1'b0) begin fails++; $display("FAIL same_cycle_ready got=%b exp=0", wr_bus.ready); end
      read_at(8'd10);
      tests++; if (rgb !== 24'h112233) begin fails++; $display("FAIL same_cycle_front got=%h exp=%h", rgb, 24'h112233); end
      wrap();
      tests++; if (swap_pulse !== 1'b1) begin fails++; $display("FAIL next_wrap_swap got=%b exp=1", swap_pulse); end
      read_at(8'd5);
      tests++; if (rgb !== 24'h778899) begin fails++; $display("FAIL next_wrap_idx5 got=%h exp=%h", rgb, 24'h778899); end
      read_at(8'd10);
      tests++; if (rgb !== 24'h0AF55A) begin fails++; $display("FAIL next_wrap_idx10 got=%h exp=%h", rgb, 24'h0AF55A); end
   endtask

   task automatic test_addr_err();
      tests++; if (addr_err !== 1'b0) begin fails++; $display("FAIL addr_err_pre got=%b exp=0", addr_err); end
      beat(8'd200, 8'hFF, 8'hFF, 8'hFF, 1'b0);
      tests++; if (addr_err !== 1'b1) begin fails++; $display("FAIL addr_err_set got=%b exp=1", addr_err); end
      tests++; if (wr_bus.ready !== 1'b1) begin fails++; $display("FAIL addr_err_ready got=%b exp=1", wr_bus.ready); end
      read_at(8'd8);
      tests++; if (rgb !== 24'h08F75A) begin fails++; $display("FAIL addr_err_ram got=%h exp=%h", rgb, 24'h08F75A); end
      read_at(8'd200);
      tests++; if (rgb !== 24'h0) begin fails++; $display("FAIL addr_200_black got=%h exp=%h", rgb, 24'h0); end
      repeat (3) @(negedge clk);
      tests++; if (addr_err !== 1'b1) begin fails++; $display("FAIL addr_err_sticky got=%b exp=1", addr_err); end
   endtask

   task automatic test_reset_mid();
      read_at(8'd30);
      #2 reset_n = 1'b0;
      #1;
      tests++; if (rgb !== 24'h0) begin fails++; $display("FAIL async_reset_rgb got=%h exp=%h", rgb, 24'h0); end
      @(negedge clk);
      tests++; if (wr_bus.ready !== 1'b1 || addr_err !== 1'b0 || swap_pulse !== 1'b0) begin
         fails++;
         $display("FAIL mid_reset_ctrl ready=%b addr_err=%b swap=%b exp 1/0/0", wr_bus.ready, addr_err, swap_pulse);
      end
      @(negedge clk);
      reset_n = 1'b1;
      read_at(8'd10);
      tests++; if (rgb !== 24'h0) begin fails++; $display("FAIL no_frame_black got=%h exp=%h", rgb, 24'h0); end
      wrap();
      tests++; if (swap_pulse !== 1'b0 || rgb !== 24'h0) begin
         fails++;
         $display("FAIL no_commit_wrap swap=%b rgb=%h exp swap=0 rgb=0", swap_pulse, rgb);
      end
      for (int k = 0; k < 64; k++) beat(8'(k), 8'(k), 8'h40, ~8'(k), k == 63);
      wrap();
      tests++; if (swap_pulse !== 1'b1) begin fails++; $display("FAIL restore_swap got=%b exp=1", swap_pulse); end
      read_at(8'd10);
      tests++; if (rgb !== 24'h0A40F5) begin fails++; $display("FAIL restore_idx10 got=%h exp=%h", rgb, 24'h0A40F5); end
      read_at(8'd63);
      tests++; if (rgb !== 24'h3F40C0) begin fails++; $display("FAIL restore_idx63 got=%h exp=%h", rgb, 24'h3F40C0); end
   endtask

   initial begin
      wr_bus.valid = 1'b0;
      wr_bus.commit = 1'b0;
      wr_bus.addr = 8'd0;
      wr_bus.red = 8'd0;
      wr_bus.green = 8'd0;
      wr_bus.blue = 8'd0;
      repeat (3) @(negedge clk);
      test_reset();
      reset_n = 1'b1;
      @(negedge clk);
      test_reset();
      test_write_commit();
      test_hold_ready();
      test_commit_on_wrap();
      test_addr_err();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
